if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 151 +++++++++++++++
 tb/tb_if_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage.
// Requests one instruction word at a time from instruction memory and presents
// it (with its PC) to the IF/ID register for one or more cycles. Redirects from
// ID may arrive while a fetch is outstanding; the stale word is then discarded.
// Optional macro IF_FETCH_CNT_EN adds a counter of accepted instructions on
// fetch_cnt_o; without it fetch_cnt_o is tied to zero.
//
// state | meaning
// ------+-----------------------------------------------------------------
// FETCH | request outstanding at fetch_addr, waiting for mem_ack_i
// VALID | instruction presented on if_pc_o/if_inst_o, no request issued
// DRAIN | redirect taken while a request was outstanding; wait for its ack,
//       | drop the data, then refetch from pc
module if_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        stallreq_o,
  output logic [31:0] fetch_cnt_o
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc;
  logic [31:0] pc_nx;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_addr_nx;
  logic [31:0] if_pc_nx;
  logic [31:0] if_inst_nx;
  logic [31:0] pc_inc;

  // Only the PC-stage stall bit matters here; the rest belong to later stages.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  // Sequential PC increment wraps naturally at 2^32.
  assign pc_inc = pc + 32'd4;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= '0;
      fetch_addr <= '0;
      if_pc_o    <= '0;
      if_inst_o  <= '0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      fetch_addr <= fetch_addr_nx;
      if_pc_o    <= if_pc_nx;
      if_inst_o  <= if_inst_nx;
    end
  end

  // Next-state and register-update decode; everything holds unless changed.
  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    fetch_addr_nx = fetch_addr;
    if_pc_nx      = if_pc_o;
    if_inst_nx    = if_inst_o;
    case (state)
      FETCH: begin
        if (branch_flag_i) begin
          pc_nx = branch_target_i;
          if (mem_ack_i) begin
            // Returned word belongs to the old path: drop it, refetch at target.
            fetch_addr_nx = branch_target_i;
          end else begin
            // Request still in flight; address must stay put until its ack.
            state_nx = DRAIN;
          end
        end else if (mem_ack_i) begin
          if_inst_nx = mem_rdata_i;
          if_pc_nx   = fetch_addr;
          state_nx   = VALID;
        end
      end
      VALID: begin
        if (branch_flag_i) begin
          // Redirect wins over stall so a flush is never held off.
          pc_nx         = branch_target_i;
          fetch_addr_nx = branch_target_i;
          if_pc_nx      = '0;
          if_inst_nx    = '0;
          state_nx      = FETCH;
        end else if (!stall[0]) begin
          pc_nx         = pc_inc;
          fetch_addr_nx = pc_inc;
          if_pc_nx      = '0;
          if_inst_nx    = '0;
          state_nx      = FETCH;
        end
      end
      DRAIN: begin
        if (branch_flag_i) begin
          pc_nx = branch_target_i;
        end
        if (mem_ack_i) begin
          // Restart from the most recent redirect target, including one
          // arriving in this very cycle.
          fetch_addr_nx = branch_flag_i ? branch_target_i : pc;
          state_nx      = FETCH;
        end
      end
      default: begin
        state_nx = FETCH;
      end
    endcase
  end

  // Memory request and stall request are pure decodes of the state.
  always_comb begin
    mem_req_o  = (state != VALID) && !rst;
    stallreq_o = (state != VALID);
    mem_addr_o = fetch_addr;
  end

`ifdef IF_FETCH_CNT_EN
  logic [31:0] fetch_cnt;

  // Counts only normal VALID->FETCH advances; flushes are not accepted work.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
    end else if ((state == VALID) && !branch_flag_i && !stall[0]) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt;
`else
  assign fetch_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed scoreboard bench for if_stage.
// Expected request addresses and presented (pc, word) pairs are queued when the
// stimulus is driven and popped when the DUT shows them. Inputs change and
// outputs are sampled around the falling clock edge.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        stallreq_o;
  logic [31:0] fetch_cnt_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] req_q[$];
  logic [31:0] vpc_q[$];
  logic [31:0] vinst_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic [31:0] e;

  if_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_ack_i       (mem_ack_i),
    .mem_rdata_i     (mem_rdata_i),
    .if_pc_o         (if_pc_o),
    .if_inst_o       (if_inst_o),
    .stallreq_o      (stallreq_o),
    .fetch_cnt_o     (fetch_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] cnt_exp();
`ifdef IF_FETCH_CNT_EN
    return m_cnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request: lat cycles without ack, then an ack carrying data, then the
  // VALID cycle is checked against the scoreboard.
  task automatic do_fetch(input int lat, input logic [31:0] data);
    logic [31:0] a;
    a = req_q.pop_front();
    for (int i = 0; i < lat; i++) begin
      mem_ack_i = 1'b0;
      #1;
      chk("req", {31'd0, mem_req_o}, 32'd1);
      chk("addr", mem_addr_o, a);
      chk("stallreq_fetch", {31'd0, stallreq_o}, 32'd1);
      chk("inst_zero_fetch", if_inst_o, 32'd0);
      @(negedge clk);
    end
    mem_ack_i   = 1'b1;
    mem_rdata_i = data;
    vpc_q.push_back(a);
    vinst_q.push_back(data);
    #1;
    chk("addr_at_ack", mem_addr_o, a);
    @(negedge clk);
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    #1;
    chk("valid_pc", if_pc_o, vpc_q.pop_front());
    chk("valid_inst", if_inst_o, vinst_q.pop_front());
    chk("stallreq_valid", {31'd0, stallreq_o}, 32'd0);
    chk("req_valid", {31'd0, mem_req_o}, 32'd0);
    chk("fetch_cnt", fetch_cnt_o, cnt_exp());
  endtask

  // Leave VALID with no stall and no branch.
  task automatic advance();
    stall         = 6'd0;
    branch_flag_i = 1'b0;
    m_pc          = m_pc + 32'd4;
    m_cnt         = m_cnt + 32'd1;
    req_q.push_back(m_pc);
    @(negedge clk);
  endtask

  initial begin
    rst             = 1'b1;
    stall           = 6'd0;
    branch_flag_i   = 1'b0;
    branch_target_i = 32'h0;
    mem_ack_i       = 1'b0;
    mem_rdata_i     = 32'h0;
    m_pc            = 32'h0;
    m_cnt           = 32'h0;

    // Reset state
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_req", {31'd0, mem_req_o}, 32'd0);
      chk("rst_addr", mem_addr_o, 32'd0);
      chk("rst_pc", if_pc_o, 32'd0);
      chk("rst_inst", if_inst_o, 32'd0);
      chk("rst_cnt", fetch_cnt_o, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Straight-line fetch of 0, 4, 8 with one-cycle ack latency
    req_q.push_back(32'h0);
    do_fetch(1, 32'h1111_0000);
    advance();
    do_fetch(1, 32'h2222_0004);
    advance();
    do_fetch(1, 32'h3333_0008);

    // Stall held three cycles in VALID at pc=8
    for (int i = 0; i < 3; i++) begin
      stall = 6'b000001;
      @(negedge clk);
      #1;
      chk("stall_pc", if_pc_o, 32'h8);
      chk("stall_inst", if_inst_o, 32'h3333_0008);
      chk("stall_stallreq", {31'd0, stallreq_o}, 32'd0);
      chk("stall_req", {31'd0, mem_req_o}, 32'd0);
    end
    advance();
    do_fetch(1, 32'h4444_000C);
    advance();

    // Redirect to 0x100 while fetch of 0x10 is outstanding; ack two cycles later
    e               = req_q.pop_front();
    mem_ack_i       = 1'b0;
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h100;
    #1;
    chk("drain_pre_addr", mem_addr_o, e);
    @(negedge clk);
    branch_flag_i = 1'b0;
    #1;
    chk("drain_stallreq", {31'd0, stallreq_o}, 32'd1);
    chk("drain_req", {31'd0, mem_req_o}, 32'd1);
    chk("drain_addr", mem_addr_o, 32'h10);
    chk("drain_inst", if_inst_o, 32'd0);
    @(negedge clk);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hDEAD_BEEF;
    #1;
    chk("drain_ack_addr", mem_addr_o, 32'h10);
    @(negedge clk);
    mem_ack_i = 1'b0;
    m_pc      = 32'h100;
    req_q.push_back(m_pc);
    do_fetch(1, 32'h5555_0100);

    // Redirect to 0x40 coincident with ack of 0x104
    advance();
    e         = req_q.pop_front();
    mem_ack_i = 1'b0;
    #1;
    chk("coinc_addr", mem_addr_o, e);
    @(negedge clk);
    mem_ack_i       = 1'b1;
    mem_rdata_i     = 32'hBAD0_0104;
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h40;
    @(negedge clk);
    mem_ack_i     = 1'b0;
    branch_flag_i = 1'b0;
    #1;
    chk("coinc_no_valid", {31'd0, stallreq_o}, 32'd1);
    chk("coinc_inst", if_inst_o, 32'd0);
    chk("coinc_addr_new", mem_addr_o, 32'h40);
    m_pc = 32'h40;
    req_q.push_back(m_pc);
    do_fetch(1, 32'h6666_0040);

    // Flush from VALID to the last word of the address space: not counted
    branch_flag_i   = 1'b1;
    branch_target_i = 32'hFFFF_FFFC;
    @(negedge clk);
    branch_flag_i = 1'b0;
    #1;
    chk("flush_cnt", fetch_cnt_o, cnt_exp());
    chk("flush_addr", mem_addr_o, 32'hFFFF_FFFC);
    m_pc = 32'hFFFF_FFFC;
    req_q.push_back(m_pc);
    do_fetch(2, 32'h7777_FFFC);

    // Wrap to 0
    advance();
    chk("wrap_addr", mem_addr_o, 32'h0);
    do_fetch(1, 32'h8888_0000);
    advance();

    // Reset during an outstanding request to 4; the pending ack is ignored
    e         = req_q.pop_front();
    mem_ack_i = 1'b0;
    #1;
    chk("prerst_addr", mem_addr_o, e);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_req", {31'd0, mem_req_o}, 32'd0);
    @(negedge clk);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hBAD0_0004;
    m_cnt       = 32'd0;
    m_pc        = 32'd0;
    #1;
    chk("midrst_req2", {31'd0, mem_req_o}, 32'd0);
    chk("midrst_cnt", fetch_cnt_o, 32'd0);
    chk("midrst_pc", if_pc_o, 32'd0);
    @(negedge clk);
    mem_ack_i = 1'b0;
    rst       = 1'b0;
    req_q.push_back(32'h0);
    do_fetch(1, 32'h9999_0000);

    // Two redirects while draining: the later target wins
    advance();
    e               = req_q.pop_front();
    mem_ack_i       = 1'b0;
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h80;
    #1;
    chk("lw_addr", mem_addr_o, e);
    @(negedge clk);
    branch_target_i = 32'h90;
    #1;
    chk("lw_drain_addr", mem_addr_o, 32'h4);
    @(negedge clk);
    branch_flag_i = 1'b0;
    mem_ack_i     = 1'b1;
    mem_rdata_i   = 32'hBAD0_0084;
    @(negedge clk);
    mem_ack_i = 1'b0;
    m_pc      = 32'h90;
    req_q.push_back(m_pc);
    do_fetch(1, 32'hAAAA_0090);
    advance();
    do_fetch(1, 32'hBBBB_0094);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
